// File: rtl/t_counter_pkg.sv
// Shared constants and TOP helper for the toggle-cell counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package t_counter_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    localparam int T_CNT_WIDTH_DEF = 4;
    localparam int T_CNT_MOD_DEF   = 10;

    // Highest count reached before wrapping back to zero.
    function automatic int t_cnt_top(input int width, input int mod_value, input bit modulo_en);
        return modulo_en ? (mod_value - 1) : ((1 << width) - 1);
    endfunction

endpackage

// File: rtl/t_ff_cell.sv
// Single toggle flip-flop with complementary outputs; resets to q=0, q_bar=1.
// Latency: 1 clock from t to inverted outputs.
// Backpressure: none; t is sampled every posedge.
module t_ff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic q_bar
);

    logic r_q;
    logic r_q_bar;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q     <= 1'b0;
            r_q_bar <= 1'b1;
        end else if (t) begin
            r_q     <= ~r_q;
            r_q_bar <= ~r_q_bar;
        end
    end

    assign q     = r_q;
    assign q_bar = r_q_bar;

endmodule

// File: rtl/t_ff_sync_counter.sv
// Up/down counter with parallel load built from toggle cells; T_CNT_MODULO_EN selects modulo-MOD_VALUE wrap.
// Latency: 1 clock from rst/load/en to q/q_bar; tc is combinational.
// Backpressure: none; inputs sampled every posedge.
module t_ff_sync_counter
    import t_counter_pkg::*;
#(
    parameter int WIDTH     = T_CNT_WIDTH_DEF,
    parameter int MOD_VALUE = T_CNT_MOD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc
);

`ifdef T_CNT_MODULO_EN
    localparam int TOP = t_cnt_top(WIDTH, MOD_VALUE, 1'b1);
`else
    localparam int TOP = t_cnt_top(WIDTH, MOD_VALUE, 1'b0);
`endif
    localparam logic [WIDTH-1:0] TOP_Q = TOP[WIDTH-1:0];

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_bar;
    logic [WIDTH-1:0] w_t;

`ifdef T_CNT_MODULO_EN
    localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MOD_VALUE);

    logic [WIDTH-1:0] w_next;

    // Out-of-range states (q >= MOD_VALUE) collapse to zero on the next enabled edge.
    always_comb begin
        w_next = w_q;
        if (load) begin
            w_next = ({1'b0, d} >= MOD_W) ? '0 : d;
        end else if (en) begin
            if (up_dn == CNT_UP) begin
                w_next = ({1'b0, w_q} >= (MOD_W - 1'b1)) ? '0 : (w_q + 1'b1);
            end else if ({1'b0, w_q} >= MOD_W) begin
                w_next = '0;
            end else begin
                w_next = (w_q == '0) ? TOP_Q : (w_q - 1'b1);
            end
        end
        w_t = w_q ^ w_next;
    end
`else
    logic w_up_run;
    logic w_dn_run;

    // Ripple of "all lower bits one" (up) or "all lower bits zero" (down) picks the toggling cells.
    always_comb begin
        w_t      = '0;
        w_up_run = 1'b1;
        w_dn_run = 1'b1;
        if (load) begin
            w_t = w_q ^ d;
        end else if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                w_t[i]   = (up_dn == CNT_UP) ? w_up_run : w_dn_run;
                w_up_run = w_up_run & w_q[i];
                w_dn_run = w_dn_run & w_q_bar[i];
            end
        end
    end
`endif

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        t_ff_cell u_cell (
            .clk   (clk),
            .rst   (rst),
            .t     (w_t[g]),
            .q     (w_q[g]),
            .q_bar (w_q_bar[g])
        );
    end

    assign q     = w_q;
    assign q_bar = w_q_bar;
    assign tc    = en & ~load & ~rst & ((up_dn == CNT_UP) ? (w_q == TOP_Q) : (w_q == '0));

endmodule

// File: tb/tb_t_ff_sync_counter.sv
// Scoreboard bench for t_ff_sync_counter (WIDTH=4, MOD_VALUE=10).
module tb_t_ff_sync_counter;

    localparam int W   = 4;
    localparam int MOD = 10;
`ifdef T_CNT_MODULO_EN
    localparam int TOPV = MOD - 1;
`else
    localparam int TOPV = (1 << W) - 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         up_dn = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] d = '0;
    logic [W-1:0] q;
    logic [W-1:0] q_bar;
    logic         tc;

    t_ff_sync_counter #(.WIDTH(W), .MOD_VALUE(MOD)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .up_dn (up_dn),
        .load  (load),
        .d     (d),
        .q     (q),
        .q_bar (q_bar),
        .tc    (tc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] sb_q[$];
    logic [W-1:0] m_q = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_next(input logic [W-1:0] cq, input logic r, input logic e,
                                                input logic u, input logic l, input logic [W-1:0] dv);
        int v;
        v = int'(cq);
        if (r) return '0;
        if (l) begin
`ifdef T_CNT_MODULO_EN
            return (int'(dv) >= MOD) ? '0 : dv;
`else
            return dv;
`endif
        end
        if (!e) return cq;
`ifdef T_CNT_MODULO_EN
        if (v >= MOD) return '0;
        if (u) return (v == MOD - 1) ? '0 : W'(v + 1);
        return (v == 0) ? W'(MOD - 1) : W'(v - 1);
`else
        if (u) return W'((v + 1) % 16);
        return W'((v + 15) % 16);
`endif
    endfunction

    task automatic step(input logic r, input logic e, input logic u, input logic l, input logic [W-1:0] dv);
        logic exp_tc;
        logic [W-1:0] exp_q;
        @(negedge clk);
        rst = r; en = e; up_dn = u; load = l; d = dv;
        #1;
        exp_tc = e & ~l & ~r & (u ? (int'(m_q) == TOPV) : (m_q == '0));
        chk("tc", {31'b0, tc}, {31'b0, exp_tc});
        sb_q.push_back(model_next(m_q, r, e, u, l, dv));
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            exp_q = sb_q.pop_front();
            chk("q", {28'b0, q}, {28'b0, exp_q});
            chk("q_bar", {28'b0, q_bar}, {28'b0, ~exp_q});
            m_q = exp_q;
        end
    endtask

    initial begin
        // Reset held with load/en active: d must be discarded.
        step(1, 1, 1, 1, 4'hA);
        step(1, 1, 1, 1, 4'hA);
        chk("rst_q_const", {28'b0, q}, 32'd0);
        chk("rst_qbar_const", {28'b0, q_bar}, 32'hF);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        // Up wrap from 13.
        step(0, 0, 1, 1, 4'd13);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
        // Down wrap from 1.
        step(0, 0, 0, 1, 4'd1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        // Load beats enable, then hold.
        step(0, 0, 1, 1, 4'd5);
        step(0, 1, 1, 1, 4'd9);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        chk("hold_const", {28'b0, q}, 32'd9);
        // Direction flip at 7.
        step(0, 0, 1, 1, 4'd6);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("flip_const", {28'b0, q}, 32'd6);
        // Reset coincident with load mid-count.
        step(0, 1, 1, 0, 0);
        step(1, 1, 1, 1, 4'hC);
`ifdef T_CNT_MODULO_EN
        step(0, 0, 1, 1, 4'd8);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("mod_wrap_const", {28'b0, q}, 32'd0);
        step(0, 1, 0, 0, 0);
        chk("mod_down_const", {28'b0, q}, 32'd9);
        step(0, 0, 1, 1, 4'd12);
        chk("mod_load_const", {28'b0, q}, 32'd0);
`endif
        for (int i = 0; i < 60; i++)
            step(($urandom_range(0, 19) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 ($urandom_range(0, 5) == 0), W'($urandom_range(0, 15)));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
